// File: rtl/sysid_boot_checker_pkg.sv
// rtl/sysid_boot_checker_pkg.sv - shared types and constants for the sysid boot checker
// Holds the FSM state type, sysid word addresses and default expected values.
package sysid_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RD_ID = 2'd1,
      ST_RD_TS = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   localparam logic [31:0] SYSID_DEFAULT_ID      = 32'd0;
   localparam logic [31:0] SYSID_DEFAULT_TS      = 32'd1518032159;
   localparam logic [15:0] SYSID_DEFAULT_TIMEOUT = 16'd1024;

   function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
      return a == b;
   endfunction

endpackage

// File: rtl/sysid_boot_checker_if.sv
// rtl/sysid_boot_checker_if.sv - Avalon-MM read port between the checker and the sysid slave
// The checker is the master; the sysid peripheral is the slave.
interface sysid_boot_checker_if;

   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;

   modport master (
      output avm_address,
      output avm_read,
      input  avm_waitrequest,
      input  avm_readdata
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      output avm_waitrequest,
      output avm_readdata
   );

endinterface

// File: rtl/sysid_boot_checker.sv
// rtl/sysid_boot_checker.sv - reads the sysid ID and timestamp words after reset and compares them
// Optional read stall timeout is compiled in with SYSID_CHECK_TIMEOUT_EN.
module sysid_boot_checker
   import sysid_chk_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
   parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
   parameter logic [15:0] TIMEOUT_CYCLES = SYSID_DEFAULT_TIMEOUT
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        start,
   sysid_boot_checker_if.master        avm,
   output logic [31:0]                 id_value,
   output logic [31:0]                 ts_value,
   output logic                        busy,
   output logic                        done,
   output logic                        id_ok,
   output logic                        ts_ok,
   output logic                        timeout
);

   state_t      state;
   state_t      state_nx;
   logic        rd_q;
   logic        addr_q;
   logic        rd_nx;
   logic        addr_nx;
   logic        busy_nx;
   logic        done_nx;
   logic        id_ok_nx;
   logic        ts_ok_nx;
   logic [31:0] id_nx;
   logic [31:0] ts_nx;
   logic        xfer_done;
   logic        start_acc;
   logic        expire;

   assign xfer_done = rd_q & ~avm.avm_waitrequest;
   assign start_acc = start & ((state == ST_IDLE) | (state == ST_DONE));

`ifdef SYSID_CHECK_TIMEOUT_EN
   logic [15:0] wait_cnt;
   logic        stall;

   assign stall  = rd_q & avm.avm_waitrequest;
   // Fires on the stall cycle that brings the count to the limit.
   assign expire = stall & (wait_cnt == TIMEOUT_CYCLES - 16'd1);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= 16'd0;
      end else if (xfer_done | expire | start_acc) begin
         wait_cnt <= 16'd0;
      end else if (stall) begin
         wait_cnt <= wait_cnt + 16'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         timeout <= 1'b0;
      end else if (start_acc) begin
         timeout <= 1'b0;
      end else if (expire) begin
         timeout <= 1'b1;
      end
   end
`else
   // Reads wait indefinitely; the limit only matters with the wait counter built in.
   assign expire  = 1'b0 & (TIMEOUT_CYCLES != 16'd0);
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_RD_ID;
         rd_q     <= 1'b0;
         addr_q   <= SYSID_ADDR_ID;
         busy     <= 1'b0;
         done     <= 1'b0;
         id_ok    <= 1'b0;
         ts_ok    <= 1'b0;
         id_value <= 32'd0;
         ts_value <= 32'd0;
      end else begin
         state    <= state_nx;
         rd_q     <= rd_nx;
         addr_q   <= addr_nx;
         busy     <= busy_nx;
         done     <= done_nx;
         id_ok    <= id_ok_nx;
         ts_ok    <= ts_ok_nx;
         id_value <= id_nx;
         ts_value <= ts_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) state_nx = ST_RD_ID;
         end
         ST_RD_ID: begin
            if (expire)         state_nx = ST_DONE;
            else if (xfer_done) state_nx = ST_RD_TS;
         end
         ST_RD_TS: begin
            if (expire | xfer_done) state_nx = ST_DONE;
         end
         default: state_nx = ST_RD_ID;
      endcase
   end

   // Read drops for one cycle after every completion so the two reads stay separate.
   always_comb begin
      rd_nx    = ((state_nx == ST_RD_ID) | (state_nx == ST_RD_TS)) & ~xfer_done;
      addr_nx  = (state_nx == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
      busy_nx  = (state_nx == ST_RD_ID) | (state_nx == ST_RD_TS);
      done_nx  = done;
      id_ok_nx = id_ok;
      ts_ok_nx = ts_ok;
      id_nx    = id_value;
      ts_nx    = ts_value;

      if (start_acc) begin
         done_nx  = 1'b0;
         id_ok_nx = 1'b0;
         ts_ok_nx = 1'b0;
      end

      if ((state == ST_RD_ID) & xfer_done) begin
         id_nx = avm.avm_readdata;
      end

      if ((state == ST_RD_TS) & xfer_done) begin
         ts_nx    = avm.avm_readdata;
         done_nx  = 1'b1;
         id_ok_nx = word_match(id_value, EXPECTED_ID);
         ts_ok_nx = word_match(avm.avm_readdata, EXPECTED_TS);
      end

      if (expire) begin
         done_nx  = 1'b1;
         id_ok_nx = 1'b0;
         ts_ok_nx = 1'b0;
      end
   end

   assign avm.avm_read    = rd_q;
   assign avm.avm_address = addr_q;

endmodule

// File: doc/sysid_boot_checker.md
SYSID_BOOT_CHECKER -- requirements
Module: sysid_boot_checker

Interface
REQ-001 Parameter EXPECTED_ID, 32'd0, expected system ID word returned at sysid address 0.
REQ-002 Parameter EXPECTED_TS, 32'd1518032159, expected build timestamp returned at sysid address 1.
REQ-003 Parameter TIMEOUT_CYCLES, 16'd1024, maximum cycles one read may stall on waitrequest.
REQ-004 clock  in  1  sole clock; all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle pulse that requests a re-check; ignored unless in IDLE or DONE.
REQ-007 avm_address  out  1  sysid word select: 0 = ID, 1 = timestamp.
REQ-008 avm_read  out  1  Avalon-MM read strobe.
REQ-009 avm_waitrequest  in  1  slave stall; the read completes in the cycle where avm_read=1 and avm_waitrequest=0.
REQ-010 avm_readdata  in  32  read data, valid in the completing cycle (zero-latency slave).
REQ-011 id_value, ts_value  out  32 each  captured ID and timestamp words.
REQ-012 busy, done, id_ok, ts_ok, timeout  out  1 each  status flags.

Function
REQ-013 FSM states: IDLE, RD_ID, RD_TS, DONE; one-hot or binary encoding is acceptable.
REQ-014 The block leaves reset in RD_ID (automatic boot check) with no start pulse required.
REQ-015 RD_ID drives avm_read=1 and avm_address=0, and holds both stable until completion.
REQ-016 On RD_ID completion: capture avm_readdata into id_value, then go to RD_TS on the next cycle.
REQ-017 RD_TS drives avm_read=1 and avm_address=1; on completion, capture into ts_value and go to DONE.
REQ-018 avm_read is deasserted in the cycle after each completion; there are no back-to-back reads, so each read is a separate transaction.
REQ-019 On entry to DONE: id_ok = (id_value==EXPECTED_ID), ts_ok = (ts_value==EXPECTED_TS), done=1; flags are registered and hold until the next check starts.
REQ-020 busy = 1 in RD_ID and RD_TS, 0 otherwise.
REQ-021 start in IDLE or DONE: clear done, id_ok, ts_ok and timeout, go to RD_ID next cycle; start in RD_ID or RD_TS is ignored.
REQ-022 Zero-wait slave: the total check takes 2 read cycles plus 1 idle cycle between them; done rises 4 cycles after the first read cycle, counting inclusively.
REQ-023 Comparisons are full 32-bit unsigned equality; no masking.

Reset
REQ-024 Async assert of reset_n drives: state=RD_ID pending, avm_read=0, avm_address=0, id_value=0, ts_value=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, wait counter=0.
REQ-025 The first avm_read assertion occurs on the first rising edge after reset_n deasserts.
REQ-026 Reset mid-read aborts the transaction immediately, discards partial results, and restarts the check from RD_ID.

Configuration
REQ-027 Macro SYSID_CHECK_TIMEOUT_EN compiled in: a 16-bit wait counter increments each cycle that avm_read=1 and avm_waitrequest=1, and clears on completion.
REQ-028 With the macro, when the counter reaches TIMEOUT_CYCLES: drop avm_read, set timeout=1, id_ok=0, ts_ok=0, done=1, and go to DONE.
REQ-029 Without the macro: no counter exists, timeout is tied to 0, and reads wait indefinitely.

Structure
REQ-030 A shared package sysid_chk_pkg holds the state enum type, the SYSID_ADDR_ID/SYSID_ADDR_TS constants (0/1), and the default EXPECTED_* values.
REQ-031 No sub-module is required; the optional timeout counter may be a sub-module named sysid_wait_timer.

Verification
REQ-032 Zero-wait slave returning 0 and 1518032159 -> done=1 at cycle 4 after reset release, id_ok=1, ts_ok=1, ts_value=32'h5A7B551F.
REQ-033 Slave returns timestamp 32'h5A7B5520 -> done=1, id_ok=1, ts_ok=0, ts_value=32'h5A7B5520.
REQ-034 waitrequest held 3 cycles on each read -> avm_read and avm_address stable throughout, done after 10 cycles, both ok flags set.
REQ-035 With SYSID_CHECK_TIMEOUT_EN and TIMEOUT_CYCLES=8, waitrequest stuck at 1 -> timeout=1 and done=1 after 8 stall cycles; id_ok=0, ts_ok=0; avm_read=0 afterwards.
REQ-036 start pulsed during RD_TS -> ignored; start pulsed in DONE -> flags clear next cycle, a new ID read begins, and the results are reproduced.
REQ-037 reset_n asserted during RD_TS -> all outputs return to zero asynchronously; after release the check reruns from address 0.
